// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: PC control from execute, imem address/data, and the
// valid/ready instruction stream toward decode.
//   master : fetch_unit side (drives imem_addr and id_*, receives the rest)
//   slave  : environment side (execute/imem/decode)
interface fetch_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            fetch_en;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic            id_valid;
    logic            id_ready;
    logic [31:0]     id_instr;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_pc_plus4;

    modport master (
        input  fetch_en, redirect_valid, redirect_pc, imem_rdata, id_ready,
        output imem_addr, id_valid, id_instr, id_pc, id_pc_plus4
    );

    modport slave (
        output fetch_en, redirect_valid, redirect_pc, imem_rdata, id_ready,
        input  imem_addr, id_valid, id_instr, id_pc, id_pc_plus4
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses a combinational imem, queues
// {pc, instr} pairs in a small FIFO and hands them to decode. Redirects reload
// the PC and flush everything queued.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fetch_if.master (fetch_en, redirect_*, imem_*, id_*)
module fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    fetch_if.master  bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [XLEN-1:0] PC_ALIGN_MASK = ~XLEN'(3);
    localparam logic [XLEN-1:0] RESET_PC_AL   = RESET_PC & PC_ALIGN_MASK;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } entry_t;

    logic [XLEN-1:0]  pc_q, pc_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];

    logic   pop_c;
    logic   push_c;
    logic   not_empty_c;
    entry_t head_c;

    // Handshake qualifiers; a full FIFO still accepts a push when the head pops.
    always_comb begin
        not_empty_c = (count_q != '0);
        pop_c       = not_empty_c & bus.id_ready;
        push_c      = bus.fetch_en & ~bus.redirect_valid &
                      ((count_q < CNT_W'(DEPTH)) | pop_c);
    end

    // Next-state: redirect overrides push/pop bookkeeping and flushes the queue.
    always_comb begin
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;

        if (bus.redirect_valid) begin
            pc_d     = bus.redirect_pc & PC_ALIGN_MASK;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) begin
                mem_d[wr_ptr_q] = '{pc: pc_q, instr: bus.imem_rdata};
                pc_d            = pc_q + XLEN'(4);
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({push_c, pop_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers; storage is cleared so id_* read zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC_AL;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    // Outputs come straight from registers (no id_ready -> id_valid path).
    always_comb begin
        head_c          = mem_q[rd_ptr_q];
        bus.imem_addr   = {2'b00, pc_q[XLEN-1:2]};
        bus.id_valid    = not_empty_c;
        bus.id_instr    = head_c.instr;
        bus.id_pc       = head_c.pc;
        bus.id_pc_plus4 = not_empty_c ? (head_c.pc + XLEN'(4)) : '0;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the combinational instruction memory.
- Owns the program counter and drives the word address into imem; imem returns the instruction in the same cycle.
- Captures each {pc, instruction} pair into a small FIFO and presents it to decode with a valid/ready handshake.
- Accepts redirects (taken branch/jump from execute), which reload the PC and flush queued instructions.

Parameters:
- XLEN, 32, datapath and PC width.
- RESET_PC, 32'h0000_0000, byte address loaded into the PC on reset.
- DEPTH, 2, fetch FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_en  in  1  1 = fetch allowed; 0 = PC holds, no pushes.
- redirect_valid  in  1  PC redirect request from execute.
- redirect_pc  in  XLEN  redirect byte address; bits [1:0] ignored (treated as 0).
- imem_addr  out  XLEN  word index to imem = {2'b00, pc[XLEN-1:2]}; combinational from the PC register.
- imem_rdata  in  32  instruction from imem, valid in the same cycle as imem_addr.
- id_valid  out  1  FIFO head valid.
- id_ready  in  1  decode accepts the head this cycle.
- id_instr  out  32  head instruction.
- id_pc  out  XLEN  head byte PC.
- id_pc_plus4  out  XLEN  id_pc + 4, modulo 2^XLEN.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - pc = RESET_PC with bits [1:0] forced to 0.
  - FIFO count, read pointer and write pointer = 0.
  - id_valid = 0. id_instr, id_pc and id_pc_plus4 read 0 while the FIFO is empty after reset.
- Definitions:
  - pop = id_valid & id_ready.
  - push = fetch_en & ~redirect_valid & (count < DEPTH | pop).
- Push: write {pc, imem_rdata} at the write pointer; pc <= pc + 4 (wraps modulo 2^XLEN); write pointer increments modulo DEPTH.
- Pop: read pointer increments modulo DEPTH.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
  - A full FIFO with a simultaneous pop does push; no bubble.
- Redirect has top priority:
  - On redirect_valid, pc <= {redirect_pc[XLEN-1:2], 2'b00}; count and both pointers clear to 0.
  - No push occurs that cycle. A pop in the same cycle is still accepted by decode and is discarded with the flush.
  - id_valid = 0 in the following cycle.
  - The first instruction at the redirect target is pushed in the next cycle (fetch_en permitting) and becomes visible to decode one cycle after that.
- Latency: an instruction fetched at cycle N is presented at id_* from cycle N+1. Steady-state throughput is 1 instruction/cycle while id_ready = 1.
- fetch_en = 0: PC and pushes freeze; pops continue, so the FIFO drains.
- Handshake stability: while id_valid = 1 and id_ready = 0, id_instr, id_pc and id_pc_plus4 stay stable until a pop or a redirect.
- id_valid does not depend combinationally on id_ready.
- imem_addr depends only on the PC register (no combinational path from redirect_pc) and updates only at clock edges or reset.
- Reset asserted mid-operation: all state returns to its reset values immediately, regardless of the clock; no partial pushes survive.

Test Plan:
- Reset release with id_ready = 1 and imem returning ROM[i] = 32'h0000_0013 + (i<<8) → imem_addr 0, 1, 2, … on successive cycles. id_pc 0x0, 0x4, 0x8 with id_instr 0x13, 0x113, 0x213 starting one cycle after release; id_pc_plus4 = id_pc + 4.
- Backpressure: id_ready = 0 for 5 cycles after the first fetch → count saturates at 2, PC stops at 0x8, head stays 0x0/0x13. Then id_ready = 1 → 0x0, 0x4, 0x8 delivered in order with no gap and no duplicate.
- Redirect while full with redirect_pc = 0x102 → next cycle id_valid = 0 and imem_addr = 0x40. The cycle after that, id_pc = 0x100 with id_instr = ROM[0x40]; old entries 0x4 and 0x8 never appear.
- Simultaneous redirect and pop: the pop is accepted, the FIFO empties, and the target fetch follows exactly as in the previous scenario.
- fetch_en = 0 for 3 cycles with id_ready = 1 → FIFO drains to id_valid = 0 and imem_addr is held. Re-enable → fetch resumes at the held PC.
- Asynchronous reset pulse mid-stream, between clock edges → id_valid drops to 0 immediately; after release fetch restarts at RESET_PC.
